// File: rtl/ifid_queue.sv
// ifid_queue: two-entry skid queue between instruction fetch and decode.
// The head entry drives decode directly from registers. The second entry
// holds a word that arrives while decode is stalled with one word queued.
module ifid_queue #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pcplus4,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcplus4,
  input  logic        out_ready,
  output logic [1:0]  count
);

  // The occupancy register doubles as the FSM state.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Field index within an entry: 0 = instr, 1 = pc, 2 = pc + 4.
  localparam int NUM_FIELDS = 3;

  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       push;
  logic       pop;
  logic       head_load_in;
  logic       head_load_tail;
  logic       tail_load_in;

  logic [NUM_FIELDS-1:0][31:0] in_field;
  logic [NUM_FIELDS-1:0][31:0] empty_field;
  logic [NUM_FIELDS-1:0][31:0] out_field;

  assign in_field    = {in_pcplus4, in_pc, in_instr};
  assign empty_field = {32'h0, 32'h0, NOP_INSTR};

  // Handshakes come only from registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_reg != ST_FULL);
  assign out_valid = (count_reg != ST_EMPTY);
  assign count     = count_reg;

  // A flush cancels both the push and the pop of its cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Datapath steering: which register captures what on this edge.
  assign head_load_in   = push && ((count_reg == ST_EMPTY) || ((count_reg == ST_ONE) && pop));
  assign head_load_tail = pop && (count_reg == ST_FULL);
  assign tail_load_in   = push && !pop && (count_reg == ST_ONE);

  // Next occupancy; flush wins over any push/pop and the unused encoding recovers to EMPTY.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = ST_EMPTY;
    end else begin
      case (count_reg)
        ST_EMPTY: if (push) count_next = ST_ONE;
        ST_ONE: begin
          if (push && !pop) begin
            count_next = ST_FULL;
          end else if (pop && !push) begin
            count_next = ST_EMPTY;
          end
        end
        ST_FULL:  if (pop) count_next = ST_ONE;
        default:  count_next = ST_EMPTY;
      endcase
    end
  end

  // Occupancy register; reset overrides flush, push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= ST_EMPTY;
    end else begin
      count_reg <= count_next;
    end
  end

  // One head/tail register pair per field. Storage is never cleared:
  // while the queue is empty its outputs are masked instead.
  generate
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      logic [31:0] head_reg;
      logic [31:0] tail_reg;

      // Head takes the incoming word, or the tail word when the tail shifts up.
      always_ff @(posedge clk) begin
        if (head_load_in) begin
          head_reg <= in_field[gi];
        end else if (head_load_tail) begin
          head_reg <= tail_reg;
        end
      end

      // Tail captures a word pushed behind a head that is not leaving.
      always_ff @(posedge clk) begin
        if (tail_load_in) begin
          tail_reg <= in_field[gi];
        end
      end

      assign out_field[gi] = (count_reg == ST_EMPTY) ? empty_field[gi] : head_reg;
    end
  endgenerate

  assign out_instr   = out_field[0];
  assign out_pc      = out_field[1];
  assign out_pcplus4 = out_field[2];

endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: directed checks of the fetch/decode queue.
// Inputs change 1 ns after a rising edge, and outputs are checked at that point.
module tb_ifid_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_pcplus4;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic        out_ready;
  logic [1:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  ifid_queue #(.NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_pcplus4  (in_pcplus4),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_pcplus4 (out_pcplus4),
    .out_ready   (out_ready),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid   = v;
    in_instr   = instr;
    in_pc      = pc;
    in_pcplus4 = pc + 32'd4;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".count"},     32'(count), 32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready"},  32'(in_ready), 32'd1);
    check({tag, ".out_instr"}, out_instr, NOP);
    check({tag, ".out_pc"},    out_pc, 32'h0);
    check({tag, ".out_pcp4"},  out_pcplus4, 32'h0);
  endtask

  task automatic check_head(input string tag, input logic [1:0] cnt,
                            input logic [31:0] instr, input logic [31:0] pc);
    check({tag, ".count"},     32'(count), 32'(cnt));
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"},  32'(in_ready), (cnt == 2'd2) ? 32'd0 : 32'd1);
    check({tag, ".out_instr"}, out_instr, instr);
    check({tag, ".out_pc"},    out_pc, pc);
    check({tag, ".out_pcp4"},  out_pcplus4, pc + 32'd4);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);

    // Reset held for two cycles
    tick();
    tick();
    check_empty("reset");

    // Streaming with decode always ready
    reset     = 1'b0;
    out_ready = 1'b1;
    offer(1'b1, 32'h00500093, 32'h0);
    tick();
    check_head("stream1", 2'd1, 32'h00500093, 32'h0);
    offer(1'b1, 32'h00A00113, 32'h4);
    tick();
    check_head("stream2", 2'd1, 32'h00A00113, 32'h4);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check_empty("stream_drain");

    // Fill while stalled, third word refused
    out_ready = 1'b0;
    offer(1'b1, 32'h11111111, 32'h100);
    tick();
    check_head("fill1", 2'd1, 32'h11111111, 32'h100);
    offer(1'b1, 32'h22222222, 32'h200);
    tick();
    check_head("fill2", 2'd2, 32'h11111111, 32'h100);
    offer(1'b1, 32'h33333333, 32'h300);
    out_ready = 1'b1;
    #1;
    check("full_in_ready_vs_out_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    tick();
    check_head("fill3_refused", 2'd2, 32'h11111111, 32'h100);
    offer(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    check_head("drain1", 2'd1, 32'h22222222, 32'h200);
    tick();
    check_empty("drain2");

    // Flush at FULL with a push and pop offered
    out_ready = 1'b0;
    offer(1'b1, 32'hAAAA0001, 32'h400);
    tick();
    offer(1'b1, 32'hAAAA0002, 32'h404);
    tick();
    check_head("pre_flush", 2'd2, 32'hAAAA0001, 32'h400);
    flush     = 1'b1;
    out_ready = 1'b1;
    offer(1'b1, 32'h44444444, 32'h408);
    tick();
    check_empty("flush");
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check_empty("post_flush");

    // Reset at ONE with a push in the same cycle
    out_ready = 1'b0;
    offer(1'b1, 32'h55555555, 32'h500);
    tick();
    check_head("pre_reset", 2'd1, 32'h55555555, 32'h500);
    reset = 1'b1;
    offer(1'b1, 32'h66666666, 32'h504);
    tick();
    check_empty("mid_reset");
    reset = 1'b0;
    offer(1'b1, 32'h77777777, 32'h600);
    tick();
    check_head("after_reset_push", 2'd1, 32'h77777777, 32'h600);
    offer(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    check_empty("after_reset_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifid_queue.md
IFID_QUEUE -- requirements
Module: ifid_queue

Interface
REQ-001: The block SHALL have the parameter NOP_INSTR, default 32'h00000013, giving the instruction word presented downstream when no valid entry exists.
REQ-002: The block SHALL have the port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003: The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004: The block SHALL have the port flush, input, 1 bit: a branch or jump redirect that discards all queued entries.
REQ-005: The block SHALL have the port in_valid, input, 1 bit: fetch presents an instruction this cycle.
REQ-006: The block SHALL have the port in_instr, input, 32 bits: the fetched instruction word.
REQ-007: The block SHALL have the port in_pc, input, 32 bits: the PC of in_instr.
REQ-008: The block SHALL have the port in_pcplus4, input, 32 bits: in_pc + 4 as computed by fetch.
REQ-009: The block SHALL have the port in_ready, output, 1 bit: the queue can accept an instruction this cycle.
REQ-010: The block SHALL have the port out_valid, output, 1 bit: the head entry is valid for decode.
REQ-011: The block SHALL have the port out_instr, output, 32 bits: the head instruction, which feeds the decoder and the immediate extender (bits 31:7).
REQ-012: The block SHALL have the port out_pc, output, 32 bits: the head PC.
REQ-013: The block SHALL have the port out_pcplus4, output, 32 bits: the head PC + 4.
REQ-014: The block SHALL have the port out_ready, input, 1 bit: decode consumes the head this cycle (the inverse of the decode stall).
REQ-015: The block SHALL have the port count, output, 2 bits: the current occupancy, 0 to 2.

Function
REQ-016: The block SHALL be a 2-entry FIFO with states EMPTY (count=0), ONE (count=1) and FULL (count=2).
REQ-017: A push SHALL occur when in_valid && in_ready && !flush.
REQ-018: A pop SHALL occur when out_valid && out_ready && !flush.
REQ-019: in_ready SHALL equal (count != 2), depend only on registered state, and have no combinational path from out_ready.
REQ-020: out_valid SHALL equal (count != 0) and be driven from registered state only.
REQ-021: out_instr, out_pc and out_pcplus4 SHALL come from the head register, and when count=0 SHALL read NOP_INSTR, 32'h0 and 32'h0 respectively.
REQ-022: State transitions SHALL be:
  - EMPTY: push goes to ONE.
  - ONE: push only goes to FULL; pop only goes to EMPTY; push and pop together stay in ONE, with the new entry becoming the head.
  - FULL: pop goes to ONE, with entry 1 shifted to the head; a push is impossible because in_ready=0.
REQ-023: Entries SHALL leave in the order they arrived, and the data of each entry SHALL be unchanged from when it was pushed.
REQ-024: Latency SHALL be one cycle: an instruction pushed at edge N appears on out_* after edge N, provided the queue was EMPTY, or ONE with a same-cycle pop.
REQ-025: flush SHALL set count to 0 at the next edge, take priority over any push or pop in the same cycle, and drop the in_* word offered in that cycle.
REQ-026: Storage registers SHALL hold their contents when no push or pop occurs; they need not be cleared on flush, but out_* SHALL still obey REQ-021.
REQ-027: count SHALL never exceed 2 and never wrap, whatever the input combination.

Reset
REQ-028: When reset=1 at a rising edge, count SHALL become 0, giving out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=0 and out_pcplus4=0.
REQ-029: Reset SHALL take priority over flush, push and pop.
REQ-030: Reset asserted mid-operation SHALL discard all entries within one edge, and the first push after reset is deasserted SHALL behave as from EMPTY.
REQ-031: Storage contents after reset SHALL be don't-care and SHALL NOT be observable on out_*.

Verification
REQ-032: The bench SHALL cover this reset case: assert reset for 2 cycles -> count=0, out_valid=0, in_ready=1, out_instr=32'h00000013.
REQ-033: The bench SHALL cover this streaming case: push 32'h00500093/pc 0x0, then 32'h00A00113/pc 0x4, with out_ready=1 -> each appears one cycle later with out_pcplus4 = pc+4, and count stays at 1.
REQ-034: The bench SHALL cover this fill and drain case: hold out_ready=0, then push 3 words -> the third is refused (in_ready=0 at count=2); release out_ready -> the first two drain in order, then count=0.
REQ-035: The bench SHALL cover this flush case: at count=2, assert flush together with in_valid and out_ready -> the next cycle has count=0, out_valid=0 and out_instr=NOP, and the offered word is never output.
REQ-036: The bench SHALL cover this mid-operation reset case: reset at count=1 with a push in the same cycle -> count=0 the next cycle, and a subsequent push appears after one cycle.
